// File: rtl/proc_mem_port_arbiter.sv
// Two-to-one memory port arbiter: round-robin grant of imem/dmem requests onto one
// registered memory request port, with a port-ID FIFO that routes in-order responses back.
package proc_mem_pkg;
  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module proc_mem_port_arbiter
  import proc_mem_pkg::*;
#(
  parameter int p_max_inflight = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  req0_msg,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  mem_req_4B_t  req1_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  output mem_resp_4B_t resp0_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,
  output mem_resp_4B_t resp1_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output mem_req_4B_t  memreq_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  input  mem_resp_4B_t memresp_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  output logic [3:0]   inflight_count,
  output logic         err_orphan
);

  localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(p_max_inflight - 1);
  localparam logic [3:0]    MAX_CNT  = 4'(p_max_inflight);

  logic                      out_val;
  mem_req_4B_t               out_msg;
  logic                      prio;
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [3:0]                count;
  logic [p_max_inflight-1:0] trk;
  logic                      err_q;

  logic load_ok;
  logic can_accept;
  logic grant;
  logic accept;
  logic empty;
  logic head_port;
  logic pop;
  logic orphan;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Space check uses the registered count, so a same-cycle pop never frees a slot.
  assign load_ok    = !out_val || memreq_rdy;
  assign can_accept = load_ok && (count < MAX_CNT);
  assign grant      = (req0_val && req1_val) ? prio : req1_val;
  assign req0_rdy   = can_accept && !grant;
  assign req1_rdy   = can_accept && grant;
  assign accept     = (req0_val && req0_rdy) || (req1_val && req1_rdy);

  assign empty     = (count == 4'd0);
  assign head_port = trk[head];

  always_comb begin
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    memresp_rdy = 1'b1;
    if (!empty) begin
      resp0_val   = memresp_val && !head_port;
      resp1_val   = memresp_val && head_port;
      memresp_rdy = head_port ? resp1_rdy : resp0_rdy;
    end
  end

  assign resp0_msg = memresp_msg;
  assign resp1_msg = memresp_msg;
  assign pop       = memresp_val && memresp_rdy && !empty;
  assign orphan    = memresp_val && empty;

  assign memreq_val     = out_val;
  assign memreq_msg     = out_msg;
  assign inflight_count = count;
  assign err_orphan     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val <= 1'b0;
      out_msg <= '0;
      prio    <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= 4'd0;
      trk     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        out_val   <= 1'b1;
        out_msg   <= grant ? req1_msg : req0_msg;
        prio      <= !grant;
        trk[tail] <= grant;
        tail      <= ptr_inc(tail);
      end else if (memreq_rdy) begin
        out_val <= 1'b0;
      end
      if (pop) head <= ptr_inc(head);
      count <= count + {3'b000, accept} - {3'b000, pop};
      if (orphan) err_q <= 1'b1;
    end
  end

endmodule
